// File: rtl/zet_fetch_pkg.sv
// Shared constants and types for the instruction fetch front end:
// 8086 prefix byte values, segment encodings and the collector state.
package zet_fetch_pkg;

    localparam logic [7:0] PFX_LOCK  = 8'hF0;
    localparam logic [7:0] PFX_REPNZ = 8'hF2;
    localparam logic [7:0] PFX_REPZ  = 8'hF3;
    localparam logic [7:0] PFX_ES    = 8'h26;
    localparam logic [7:0] PFX_CS    = 8'h2E;
    localparam logic [7:0] PFX_SS    = 8'h36;
    localparam logic [7:0] PFX_DS    = 8'h3E;

    localparam logic [1:0] SEG_ES = 2'd0;
    localparam logic [1:0] SEG_CS = 2'd1;
    localparam logic [1:0] SEG_SS = 2'd2;
    localparam logic [1:0] SEG_DS = 2'd3;

    typedef enum logic [0:0] {
        PFX  = 1'b0,
        HOLD = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/zet_prefix_fetch_if.sv
// Byte-stream, decoder-handshake and decoded-prefix bundle of the prefix
// collector; slave is the collector side, master the feeding/consuming side.
interface zet_prefix_fetch_if #(
    parameter int CNT_W = 4
);
    logic [7:0]       byte_in;
    logic             byte_valid;
    logic             byte_ready;
    logic             flush;
    logic             op_ack;
    logic             rep_again;
    logic [1:0]       prefix;
    logic             seg_ovr;
    logic [1:0]       seg;
    logic             lock;
    logic [7:0]       opcode;
    logic             op_valid;
    logic [CNT_W-1:0] prefix_cnt;
    logic             pfx_err;

    modport slave (
        input  byte_in, byte_valid, flush, op_ack, rep_again,
        output byte_ready, prefix, seg_ovr, seg, lock, opcode, op_valid,
               prefix_cnt, pfx_err
    );

    modport master (
        output byte_in, byte_valid, flush, op_ack, rep_again,
        input  byte_ready, prefix, seg_ovr, seg, lock, opcode, op_valid,
               prefix_cnt, pfx_err
    );
endinterface

// File: rtl/zet_prefix_classify.sv
// Combinational classifier: tells which 8086 prefix class a byte belongs to.
module zet_prefix_classify
    import zet_fetch_pkg::*;
(
    input  logic [7:0] byte_in,
    output logic       is_prefix,
    output logic       is_rep,
    output logic       rep_z,
    output logic       is_seg,
    output logic [1:0] seg_code,
    output logic       is_lock
);

    // Decode the byte against the prefix table.
    always_comb begin
        is_rep   = 1'b0;
        rep_z    = 1'b0;
        is_seg   = 1'b0;
        seg_code = SEG_ES;
        is_lock  = 1'b0;
        case (byte_in)
            PFX_LOCK:  is_lock = 1'b1;
            PFX_REPNZ: is_rep  = 1'b1;
            PFX_REPZ:  begin is_rep = 1'b1; rep_z = 1'b1; end
            PFX_ES:    begin is_seg = 1'b1; seg_code = SEG_ES; end
            PFX_CS:    begin is_seg = 1'b1; seg_code = SEG_CS; end
            PFX_SS:    begin is_seg = 1'b1; seg_code = SEG_SS; end
            PFX_DS:    begin is_seg = 1'b1; seg_code = SEG_DS; end
            default:   is_lock = 1'b0;
        endcase
        is_prefix = is_rep | is_seg | is_lock;
    end

endmodule

// File: rtl/zet_prefix_fetch.sv
// Prefix collector: gathers 8086 prefixes, latches the opcode and holds the
// decoded instruction across REP re-executions.
module zet_prefix_fetch
    import zet_fetch_pkg::*;
#(
    parameter int MAX_PREFIX = 14,
    parameter int CNT_W      = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    zet_prefix_fetch_if.slave   bus
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PREFIX);

    fetch_state_e     state_r, state_s;
    logic [1:0]       prefix_r, prefix_s;
    logic             seg_ovr_r, seg_ovr_s;
    logic [1:0]       seg_r, seg_s;
    logic             lock_r, lock_s;
    logic [7:0]       opcode_r, opcode_s;
    logic             op_valid_r, op_valid_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             pfx_err_r, pfx_err_s;
    logic             ready_en_r;
    logic             accept_s;

    logic       is_prefix_s, is_rep_s, rep_z_s, is_seg_s, is_lock_s;
    logic [1:0] seg_code_s;

    zet_prefix_classify u_classify (
        .byte_in   (bus.byte_in),
        .is_prefix (is_prefix_s),
        .is_rep    (is_rep_s),
        .rep_z     (rep_z_s),
        .is_seg    (is_seg_s),
        .seg_code  (seg_code_s),
        .is_lock   (is_lock_s)
    );

    // ready_en_r keeps byte_ready low until one clock after reset release
    assign bus.byte_ready = ready_en_r & (state_r == PFX) & ~bus.flush;
    assign accept_s       = bus.byte_valid & bus.byte_ready;

    // Next-state and next-field logic.
    always_comb begin
        state_s    = state_r;
        prefix_s   = prefix_r;
        seg_ovr_s  = seg_ovr_r;
        seg_s      = seg_r;
        lock_s     = lock_r;
        opcode_s   = opcode_r;
        op_valid_s = op_valid_r;
        cnt_s      = cnt_r;
        pfx_err_s  = 1'b0;
        if (bus.flush) begin
            state_s    = PFX;
            prefix_s   = 2'b00;
            seg_ovr_s  = 1'b0;
            seg_s      = 2'b00;
            lock_s     = 1'b0;
            opcode_s   = 8'h00;
            op_valid_s = 1'b0;
            cnt_s      = '0;
        end else begin
            case (state_r)
                PFX: begin
                    if (accept_s && is_prefix_s && (cnt_r == MAX_CNT)) begin
                        // too many prefixes: drop the instruction's prefix state
                        pfx_err_s = 1'b1;
                        prefix_s  = 2'b00;
                        seg_ovr_s = 1'b0;
                        seg_s     = 2'b00;
                        lock_s    = 1'b0;
                        cnt_s     = '0;
                    end else if (accept_s && is_prefix_s) begin
                        cnt_s = cnt_r + CNT_W'(1);
                        if (is_rep_s) begin
                            prefix_s = {1'b1, rep_z_s};
                        end else if (is_seg_s) begin
                            seg_ovr_s = 1'b1;
                            seg_s     = seg_code_s;
                        end else begin
                            lock_s = is_lock_s | lock_r;
                        end
                    end else if (accept_s) begin
                        opcode_s   = bus.byte_in;
                        op_valid_s = 1'b1;
                        state_s    = HOLD;
                    end else begin
                        state_s = PFX;
                    end
                end
                HOLD: begin
                    if (bus.op_ack && op_valid_r && !bus.rep_again) begin
                        state_s    = PFX;
                        prefix_s   = 2'b00;
                        seg_ovr_s  = 1'b0;
                        seg_s      = 2'b00;
                        lock_s     = 1'b0;
                        opcode_s   = 8'h00;
                        op_valid_s = 1'b0;
                        cnt_s      = '0;
                    end else begin
                        state_s = HOLD;
                    end
                end
                default: state_s = PFX;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= PFX;
            prefix_r   <= 2'b00;
            seg_ovr_r  <= 1'b0;
            seg_r      <= 2'b00;
            lock_r     <= 1'b0;
            opcode_r   <= 8'h00;
            op_valid_r <= 1'b0;
            cnt_r      <= '0;
            pfx_err_r  <= 1'b0;
            ready_en_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            prefix_r   <= prefix_s;
            seg_ovr_r  <= seg_ovr_s;
            seg_r      <= seg_s;
            lock_r     <= lock_s;
            opcode_r   <= opcode_s;
            op_valid_r <= op_valid_s;
            cnt_r      <= cnt_s;
            pfx_err_r  <= pfx_err_s;
            ready_en_r <= 1'b1;
        end
    end

    assign bus.prefix     = prefix_r;
    assign bus.seg_ovr    = seg_ovr_r;
    assign bus.seg        = seg_r;
    assign bus.lock       = lock_r;
    assign bus.opcode     = opcode_r;
    assign bus.op_valid   = op_valid_r;
    assign bus.prefix_cnt = cnt_r;
    assign bus.pfx_err    = pfx_err_r;

endmodule

// File: tb/tb_zet_prefix_fetch.sv
// Directed bench for zet_prefix_fetch: expected decodes are queued when the
// opcode byte is driven and compared when op_valid appears.
module tb_zet_prefix_fetch;

    typedef struct packed {
        logic [1:0] prefix;
        logic       seg_ovr;
        logic [1:0] seg;
        logic       lock;
        logic [7:0] opcode;
        logic [3:0] cnt;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    exp_t exp_q[$];

    zet_prefix_fetch_if #(.CNT_W(4)) bus ();

    zet_prefix_fetch #(.MAX_PREFIX(14), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_byte(input logic [7:0] b);
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        tick();
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'h00;
    endtask

    task automatic push_exp(input logic [1:0] p, input logic so, input logic [1:0] sg,
                            input logic lk, input logic [7:0] op, input logic [3:0] c);
        exp_t e;
        e.prefix = p; e.seg_ovr = so; e.seg = sg; e.lock = lk; e.opcode = op; e.cnt = c;
        exp_q.push_back(e);
    endtask

    // Called right after the opcode byte's accepting edge: op_valid must already be up.
    task automatic wait_op(input string tag);
        int   n;
        exp_t e;
        n = 0;
        while (bus.op_valid !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, 0);
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_op_valid"}, bus.op_valid, 1);
            chk({tag, "_prefix"},   bus.prefix,   e.prefix);
            chk({tag, "_seg_ovr"},  bus.seg_ovr,  e.seg_ovr);
            chk({tag, "_seg"},      bus.seg,      e.seg);
            chk({tag, "_lock"},     bus.lock,     e.lock);
            chk({tag, "_opcode"},   bus.opcode,   e.opcode);
            chk({tag, "_cnt"},      bus.prefix_cnt, e.cnt);
        end
    endtask

    task automatic ack_done(input string tag);
        bus.op_ack = 1'b1; bus.rep_again = 1'b0;
        tick();
        bus.op_ack = 1'b0;
        chk({tag, "_ack_op_valid"}, bus.op_valid, 0);
        chk({tag, "_ack_opcode"},   bus.opcode,   0);
        chk({tag, "_ack_cnt"},      bus.prefix_cnt, 0);
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst_n = 1'b0;
        bus.byte_in = 8'h00; bus.byte_valid = 1'b0; bus.flush = 1'b0;
        bus.op_ack = 1'b0; bus.rep_again = 1'b0;

        // reset state
        #3;
        chk("rst_op_valid",   bus.op_valid, 0);
        chk("rst_prefix",     bus.prefix, 0);
        chk("rst_opcode",     bus.opcode, 0);
        chk("rst_cnt",        bus.prefix_cnt, 0);
        chk("rst_pfx_err",    bus.pfx_err, 0);
        chk("rst_byte_ready", bus.byte_ready, 0);
        tick(); tick();
        rst_n = 1'b1;
        chk("release_byte_ready_low", bus.byte_ready, 0);
        tick();
        chk("release_byte_ready_high", bus.byte_ready, 1);

        // plain opcode
        push_exp(2'b00, 1'b0, 2'd0, 1'b0, 8'h90, 4'd0);
        drive_byte(8'h90);
        wait_op("plain");
        chk("plain_hold_ready", bus.byte_ready, 0);
        ack_done("plain");

        // prefix stack: later REP overrides earlier
        drive_byte(8'h2E);
        drive_byte(8'hF2);
        chk("stack_repnz", bus.prefix, 2'b10);
        drive_byte(8'hF3);
        push_exp(2'b11, 1'b1, 2'd1, 1'b0, 8'hA6, 4'd3);
        drive_byte(8'hA6);
        wait_op("stack");
        ack_done("stack");

        // LOCK + SS override + override replacement
        drive_byte(8'hF0);
        drive_byte(8'h26);
        drive_byte(8'h36);
        push_exp(2'b00, 1'b1, 2'd2, 1'b1, 8'h89, 4'd3);
        drive_byte(8'h89);
        wait_op("lock");
        ack_done("lock");

        // REP hold: five re-executes, a byte waiting that must not be taken
        drive_byte(8'hF3);
        push_exp(2'b11, 1'b0, 2'd0, 1'b0, 8'hA4, 4'd1);
        drive_byte(8'hA4);
        wait_op("rep");
        for (int i = 0; i < 5; i++) begin
            bus.byte_in = 8'h26; bus.byte_valid = 1'b1;
            bus.op_ack = 1'b1; bus.rep_again = 1'b1;
            tick();
            chk("rep_iter_op_valid", bus.op_valid, 1);
            chk("rep_iter_opcode",   bus.opcode, 8'hA4);
            chk("rep_iter_prefix",   bus.prefix, 2'b11);
            chk("rep_iter_seg_ovr",  bus.seg_ovr, 0);
            chk("rep_iter_cnt",      bus.prefix_cnt, 1);
            chk("rep_iter_ready",    bus.byte_ready, 0);
        end
        bus.byte_valid = 1'b0; bus.byte_in = 8'h00;
        ack_done("rep");
        chk("rep_end_prefix", bus.prefix, 0);

        // prefix limit
        for (int i = 0; i < 14; i++) drive_byte(8'h26);
        chk("limit_cnt14", bus.prefix_cnt, 14);
        chk("limit_seg_ovr", bus.seg_ovr, 1);
        chk("limit_no_err", bus.pfx_err, 0);
        drive_byte(8'h26);
        chk("limit_err_pulse", bus.pfx_err, 1);
        chk("limit_cnt_clr", bus.prefix_cnt, 0);
        chk("limit_seg_clr", bus.seg_ovr, 0);
        tick();
        chk("limit_err_one_cycle", bus.pfx_err, 0);
        push_exp(2'b00, 1'b0, 2'd0, 1'b0, 8'h90, 4'd0);
        drive_byte(8'h90);
        wait_op("limit");
        ack_done("limit");

        // flush race in PFX: pending REP cleared, DS byte refused
        drive_byte(8'hF3);
        bus.byte_in = 8'h3E; bus.byte_valid = 1'b1; bus.flush = 1'b1;
        #1;
        chk("flush_ready_low", bus.byte_ready, 0);
        tick();
        bus.byte_valid = 1'b0; bus.flush = 1'b0;
        chk("flush_pfx_seg", bus.seg_ovr, 0);
        chk("flush_pfx_prefix", bus.prefix, 0);
        chk("flush_pfx_cnt", bus.prefix_cnt, 0);

        // flush in HOLD beats op_ack & rep_again
        push_exp(2'b00, 1'b0, 2'd0, 1'b0, 8'hC3, 4'd0);
        drive_byte(8'hC3);
        wait_op("flush_hold");
        bus.op_ack = 1'b1; bus.rep_again = 1'b1; bus.flush = 1'b1;
        tick();
        bus.op_ack = 1'b0; bus.rep_again = 1'b0; bus.flush = 1'b0;
        chk("flush_hold_op_valid", bus.op_valid, 0);
        chk("flush_hold_opcode", bus.opcode, 0);
        #1;
        chk("flush_hold_ready", bus.byte_ready, 1);

        // async reset between edges while holding a REP instruction
        tick();
        drive_byte(8'hF2);
        push_exp(2'b10, 1'b0, 2'd0, 1'b0, 8'hAE, 4'd1);
        drive_byte(8'hAE);
        wait_op("areset");
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_op_valid", bus.op_valid, 0);
        chk("areset_prefix",   bus.prefix, 0);
        chk("areset_opcode",   bus.opcode, 0);
        chk("areset_ready",    bus.byte_ready, 0);
        tick();
        rst_n = 1'b1;
        tick();

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
